// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter decoder.
package ring_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // Rotate the low w bits of x left by one; bit w-1 wraps to bit 0.
   function automatic logic [15:0] rotl(input logic [15:0] x, input int w);
      logic [15:0] res;
      res = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < w) res[(i + 1 == w) ? 0 : i + 1] = x[i];
      end
      return res;
   endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder that also flags whether exactly one bit is set.
module onehot_enc
   import ring_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0]         i_vec,
   output logic [$clog2(WIDTH)-1:0] o_index,
   output logic                     o_is_onehot
);

   localparam int IW = $clog2(WIDTH);
   localparam int CW = IW + 1;

   logic [CW-1:0] w_ones;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      o_index = '0;
      w_ones  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_vec[i]) o_index = IW'(i);
         w_ones = w_ones + CW'(i_vec[i]);
      end
      o_is_onehot = (w_ones == CW'(1));
   end

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter decoder: hunts, acquires and tracks a rotating one-hot pattern.
// Optional rotation counter (wrap/rot_cnt) enabled by `define RING_DECODER_ROT_CNT_EN.
module ring_decoder
   import ring_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int LOCK_COUNT = 2,
   parameter int MISS_LIMIT = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         ring_in,
   input  logic                     ring_valid,
   input  logic                     clear_err,
   output logic [$clog2(WIDTH)-1:0] pos,
   output logic                     locked,
   output logic                     err,
   output logic [7:0]               err_cnt,
   output logic                     wrap,
   output logic [7:0]               rot_cnt
);

   localparam int              PW        = $clog2(WIDTH);
   localparam logic [2:0]      LOCK_CNT3 = 3'(LOCK_COUNT);
   localparam logic [2:0]      MISS_LIM3 = 3'(MISS_LIMIT);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_ref, w_ref_nxt, w_rot;
   logic [PW-1:0]    r_pos, w_pos_nxt, w_in_idx;
   logic [2:0]       r_good, w_good_nxt, w_good_inc;
   logic [2:0]       r_miss, w_miss_nxt, w_miss_inc;
   logic             w_in_onehot, w_match, w_miss_evt;
   logic             r_locked, r_err, w_err_nxt;
   logic [7:0]       r_err_cnt, w_err_cnt_nxt;

   onehot_enc #(.WIDTH(WIDTH)) u_enc (
      .i_vec       (ring_in),
      .o_index     (w_in_idx),
      .o_is_onehot (w_in_onehot)
   );

   assign w_rot      = WIDTH'(rotl(16'(r_ref), WIDTH));
   assign w_match    = (ring_in == w_rot);
   assign w_good_inc = r_good + 3'd1;
   assign w_miss_inc = r_miss + 3'd1;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= HUNT;
         r_ref     <= WIDTH'(1);
         r_pos     <= '0;
         r_good    <= '0;
         r_miss    <= '0;
         r_locked  <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_ref     <= w_ref_nxt;
         r_pos     <= w_pos_nxt;
         r_good    <= w_good_nxt;
         r_miss    <= w_miss_nxt;
         r_locked  <= (w_state_nxt == LOCKED);
         r_err     <= w_err_nxt;
         r_err_cnt <= w_err_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ref_nxt   = r_ref;
      w_pos_nxt   = r_pos;
      w_good_nxt  = r_good;
      w_miss_nxt  = r_miss;
      w_miss_evt  = 1'b0;
      if (ring_valid) begin
         unique case (r_state)
            HUNT: begin
               if (w_in_onehot) begin
                  w_ref_nxt = ring_in;
                  w_pos_nxt = w_in_idx;
                  if (LOCK_COUNT == 1) begin
                     w_state_nxt = LOCKED;
                     w_good_nxt  = '0;
                  end else begin
                     w_state_nxt = ACQUIRE;
                     w_good_nxt  = 3'd1;
                  end
               end
            end
            ACQUIRE: begin
               if (w_match) begin
                  w_ref_nxt = ring_in;
                  w_pos_nxt = w_in_idx;
                  if (w_good_inc == LOCK_CNT3) begin
                     w_state_nxt = LOCKED;
                     w_good_nxt  = '0;
                  end else begin
                     w_good_nxt  = w_good_inc;
                  end
               end else if (w_in_onehot) begin
                  w_ref_nxt  = ring_in;
                  w_pos_nxt  = w_in_idx;
                  w_good_nxt = 3'd1;
               end else begin
                  w_state_nxt = HUNT;
                  w_good_nxt  = '0;
               end
            end
            LOCKED: begin
               if (w_match) begin
                  w_ref_nxt  = ring_in;
                  w_pos_nxt  = w_in_idx;
                  w_miss_nxt = '0;
               end else begin
                  // Flywheel: keep advancing the reference through the bad sample.
                  w_miss_evt = 1'b1;
                  w_ref_nxt  = w_rot;
                  w_pos_nxt  = r_pos + PW'(1);
                  if (w_miss_inc == MISS_LIM3) begin
                     w_state_nxt = HUNT;
                     w_miss_nxt  = '0;
                  end else begin
                     w_miss_nxt  = w_miss_inc;
                  end
               end
            end
            default: w_state_nxt = HUNT;
         endcase
      end
   end

   always_comb begin
      w_err_nxt     = w_miss_evt;
      w_err_cnt_nxt = r_err_cnt;
      if (clear_err)                          w_err_cnt_nxt = '0;
      else if (w_miss_evt && r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
   end

   assign pos     = r_pos;
   assign locked  = r_locked;
   assign err     = r_err;
   assign err_cnt = r_err_cnt;

`ifdef RING_DECODER_ROT_CNT_EN
   logic       w_hit_locked, w_wrap_nxt, r_wrap;
   logic [7:0] r_rot_cnt;

   assign w_hit_locked = ring_valid && (r_state == LOCKED) && w_match;
   assign w_wrap_nxt   = w_hit_locked && (r_pos == PW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrap    <= 1'b0;
         r_rot_cnt <= '0;
      end else begin
         r_wrap <= w_wrap_nxt;
         if (w_wrap_nxt) r_rot_cnt <= r_rot_cnt + 8'd1;
      end
   end

   assign wrap    = r_wrap;
   assign rot_cnt = r_rot_cnt;
`else
   assign wrap    = 1'b0;
   assign rot_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// Directed self-checking bench for ring_decoder (WIDTH=8, LOCK_COUNT=2, MISS_LIMIT=3).
module tb_ring_decoder;

`ifdef RING_DECODER_ROT_CNT_EN
   localparam logic ROT = 1'b1;
`else
   localparam logic ROT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] ring_in = '0;
   logic       ring_valid = 1'b0;
   logic       clear_err = 1'b0;
   logic [2:0] pos;
   logic       locked, err, wrap;
   logic [7:0] err_cnt, rot_cnt;

   int n_checks = 0;
   int n_fails  = 0;
   logic [7:0] exp_ref;

   ring_decoder #(.WIDTH(8), .LOCK_COUNT(2), .MISS_LIMIT(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .ring_in    (ring_in),
      .ring_valid (ring_valid),
      .clear_err  (clear_err),
      .pos        (pos),
      .locked     (locked),
      .err        (err),
      .err_cnt    (err_cnt),
      .wrap       (wrap),
      .rot_cnt    (rot_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] brot(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Apply one sample for one clock, then sample outputs 1 time unit after the edge.
   task automatic step(input logic [7:0] d, input logic v, input logic c);
      ring_in    = d;
      ring_valid = v;
      clear_err  = c;
      @(posedge clk);
      #1;
      ring_valid = 1'b0;
      clear_err  = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pos"},     16'(pos),     16'd0);
      check({tag, "_locked"},  16'(locked),  16'd0);
      check({tag, "_err"},     16'(err),     16'd0);
      check({tag, "_err_cnt"}, 16'(err_cnt), 16'd0);
      check({tag, "_wrap"},    16'(wrap),    16'd0);
      check({tag, "_rot_cnt"}, 16'(rot_cnt), 16'd0);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step(8'h00, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      check_reset_state("rst");

      // Acquire and lock on 01,02,04
      step(8'h01, 1'b1, 1'b0);
      check("acq1_locked", 16'(locked), 16'd0);
      check("acq1_pos",    16'(pos),    16'd0);
      step(8'h02, 1'b1, 1'b0);
      check("acq2_locked", 16'(locked), 16'd1);
      step(8'h04, 1'b1, 1'b0);
      check("lock_locked", 16'(locked), 16'd1);
      check("lock_pos",    16'(pos),    16'd2);
      check("lock_err",    16'(err),    16'd0);

      // Track up to 0x80, then wrap to 0x01
      step(8'h08, 1'b1, 1'b0);
      step(8'h10, 1'b1, 1'b0);
      step(8'h20, 1'b1, 1'b0);
      step(8'h40, 1'b1, 1'b0);
      step(8'h80, 1'b1, 1'b0);
      check("at80_pos",  16'(pos),  16'd7);
      check("at80_wrap", 16'(wrap), 16'd0);
      step(8'h01, 1'b1, 1'b0);
      check("wrap_pulse",   16'(wrap),    16'(ROT));
      check("wrap_pos",     16'(pos),     16'd0);
      check("wrap_rot_cnt", 16'(rot_cnt), 16'(ROT));
      step(8'h02, 1'b1, 1'b0);
      check("post_wrap_pulse", 16'(wrap), 16'd0);
      check("post_wrap_pos",   16'(pos),  16'd1);

      // Invalid samples are ignored
      step(8'h00, 1'b0, 1'b0);
      check("novalid_pos", 16'(pos), 16'd1);
      check("novalid_err", 16'(err), 16'd0);

      // Single multi-hot glitch while locked, then resume on the flywheel sequence
      step(8'h11, 1'b1, 1'b0);
      check("glitch_err",     16'(err),     16'd1);
      check("glitch_err_cnt", 16'(err_cnt), 16'd1);
      check("glitch_pos",     16'(pos),     16'd2);
      check("glitch_locked",  16'(locked),  16'd1);
      step(8'h08, 1'b1, 1'b0);
      check("resume_err",     16'(err),     16'd0);
      check("resume_err_cnt", 16'(err_cnt), 16'd1);
      check("resume_pos",     16'(pos),     16'd3);
      check("resume_locked",  16'(locked),  16'd1);
      step(8'h10, 1'b1, 1'b0);
      step(8'h20, 1'b1, 1'b0);
      step(8'h40, 1'b1, 1'b0);
      step(8'h80, 1'b1, 1'b0);
      step(8'h01, 1'b1, 1'b0);
      check("wrap2_rot_cnt", 16'(rot_cnt), ROT ? 16'd2 : 16'd0);
      step(8'h02, 1'b1, 1'b0);
      step(8'h04, 1'b1, 1'b0);

      // Clear without an error
      step(8'h00, 1'b0, 1'b1);
      check("clear_err_cnt", 16'(err_cnt), 16'd0);

      // Three all-zero samples drop lock
      step(8'h00, 1'b1, 1'b0);
      check("miss1_err", 16'(err), 16'd1);
      check("miss1_cnt", 16'(err_cnt), 16'd1);
      check("miss1_pos", 16'(pos), 16'd3);
      check("miss1_locked", 16'(locked), 16'd1);
      step(8'h00, 1'b1, 1'b0);
      check("miss2_cnt", 16'(err_cnt), 16'd2);
      check("miss2_pos", 16'(pos), 16'd4);
      step(8'h00, 1'b1, 1'b0);
      check("miss3_err", 16'(err), 16'd1);
      check("miss3_cnt", 16'(err_cnt), 16'd3);
      check("miss3_pos", 16'(pos), 16'd5);
      check("miss3_locked", 16'(locked), 16'd0);
      step(8'h00, 1'b1, 1'b0);
      check("hunt_zero_err", 16'(err), 16'd0);
      check("hunt_zero_cnt", 16'(err_cnt), 16'd3);

      // Relock, then two misses plus one good step per pass to saturate err_cnt
      step(8'h01, 1'b1, 1'b0);
      step(8'h02, 1'b1, 1'b0);
      check("relock_locked", 16'(locked), 16'd1);
      exp_ref = 8'h02;
      for (int k = 0; k < 126; k++) begin
         step(8'h00, 1'b1, 1'b0);
         exp_ref = brot(exp_ref);
         step(8'h00, 1'b1, 1'b0);
         exp_ref = brot(exp_ref);
         exp_ref = brot(exp_ref);
         step(exp_ref, 1'b1, 1'b0);
      end
      check("sat_err_cnt", 16'(err_cnt), 16'd255);
      check("sat_locked",  16'(locked),  16'd1);
      check("sat_pos",     16'(pos),     16'd3);
      step(8'h00, 1'b1, 1'b0);
      exp_ref = brot(exp_ref);
      check("sat_hold_cnt", 16'(err_cnt), 16'd255);
      check("sat_hold_err", 16'(err),     16'd1);
      step(8'h00, 1'b1, 1'b1);
      exp_ref = brot(exp_ref);
      check("clr_vs_err_cnt", 16'(err_cnt), 16'd0);
      check("clr_vs_err_err", 16'(err),     16'd1);
      check("clr_vs_err_lck", 16'(locked),  16'd1);
      exp_ref = brot(exp_ref);
      step(exp_ref, 1'b1, 1'b0);
      check("post_clr_err",    16'(err),    16'd0);
      check("post_clr_locked", 16'(locked), 16'd1);

      // Reset while locked with a valid matching sample and clear_err asserted
      rst = 1'b1;
      step(brot(exp_ref), 1'b1, 1'b1);
      rst = 1'b0;
      check_reset_state("midrst");
      step(8'h02, 1'b1, 1'b0);
      check("midrst_hunt_locked", 16'(locked), 16'd0);
      check("midrst_hunt_pos",    16'(pos),    16'd1);
      step(8'h04, 1'b1, 1'b0);
      check("midrst_relock", 16'(locked), 16'd1);

      // ACQUIRE corner cases
      rst = 1'b1;
      step(8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      step(8'h08, 1'b1, 1'b0);
      step(8'h03, 1'b1, 1'b0);
      check("acq_bad_pos",    16'(pos),    16'd3);
      check("acq_bad_locked", 16'(locked), 16'd0);
      step(8'h10, 1'b1, 1'b0);
      check("acq_rehunt_locked", 16'(locked), 16'd0);
      step(8'h01, 1'b1, 1'b0);
      check("acq_restart_pos",    16'(pos),    16'd0);
      check("acq_restart_locked", 16'(locked), 16'd0);
      step(8'h02, 1'b1, 1'b0);
      check("acq_restart_lock", 16'(locked), 16'd1);
      check("acq_no_err",       16'(err),    16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
